// File: rtl/pc_fetch_unit.sv
// Program counter and IF/ID register: redirect > stall > sequential for the PC; bubble > hold > capture for IF/ID.
// One cycle from PC to IF/ID; Stall freezes both the PC and IF/ID, and a redirect overrides Stall.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Stall,
   input  logic             Flush,
   input  logic             BranchTaken,
   input  logic [31:0]      BranchTarget,
   input  logic             Jump,
   input  logic [31:0]      JumpTarget,
   input  logic [31:0]      PCAddResult,
   input  logic [31:0]      Instruction,
   output logic [31:0]      PCResult,
   output logic [31:0]      IFID_Instruction,
   output logic [31:0]      IFID_PCPlus4,
   output logic             IFID_Valid,
   output logic [CNT_W-1:0] FetchCount,
   output logic             MisalignFlag
);

   logic [31:0]      pc_q,       pc_d;
   logic [31:0]      ifid_ins_q, ifid_ins_d;
   logic [31:0]      ifid_pc4_q, ifid_pc4_d;
   logic             ifid_vld_q, ifid_vld_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic             misalign_q, misalign_d;
   logic             redirect;

   assign redirect = Jump | BranchTaken;

   always_comb begin
      pc_d       = pc_q;
      misalign_d = misalign_q;
      if (Jump) begin
         pc_d = {JumpTarget[31:2], 2'b00};
         if (JumpTarget[1:0] != 2'b00) misalign_d = 1'b1;
      end else if (BranchTaken) begin
         pc_d = {BranchTarget[31:2], 2'b00};
         if (BranchTarget[1:0] != 2'b00) misalign_d = 1'b1;
      end else if (!Stall) begin
         pc_d = PCAddResult;
      end
   end

   // A bubble writes a NOP; the fetch counter only moves on a real capture.
   always_comb begin
      ifid_ins_d = ifid_ins_q;
      ifid_pc4_d = ifid_pc4_q;
      ifid_vld_d = ifid_vld_q;
      cnt_d      = cnt_q;
      if (redirect || Flush) begin
         ifid_ins_d = 32'h0;
         ifid_pc4_d = 32'h0;
         ifid_vld_d = 1'b0;
      end else if (!Stall) begin
         ifid_ins_d = Instruction;
         ifid_pc4_d = PCAddResult;
         ifid_vld_d = 1'b1;
         cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pc_q       <= RESET_PC;
         ifid_ins_q <= 32'h0;
         ifid_pc4_q <= 32'h0;
         ifid_vld_q <= 1'b0;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ifid_ins_q <= ifid_ins_d;
         ifid_pc4_q <= ifid_pc4_d;
         ifid_vld_q <= ifid_vld_d;
         cnt_q      <= cnt_d;
         misalign_q <= misalign_d;
      end
   end

   assign PCResult         = pc_q;
   assign IFID_Instruction = ifid_ins_q;
   assign IFID_PCPlus4     = ifid_pc4_q;
   assign IFID_Valid       = ifid_vld_q;
   assign FetchCount       = cnt_q;
   assign MisalignFlag     = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; a second 3-bit-counter instance exposes counter wrap.
module tb_pc_fetch_unit;

   localparam logic [31:0] K = 32'hDEAD_0000;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Stall, Flush, BranchTaken, Jump;
   logic [31:0] BranchTarget, JumpTarget;
   logic [31:0] PCAddResult, Instruction;
   logic [31:0] PCResult, IFID_Instruction, IFID_PCPlus4;
   logic        IFID_Valid, MisalignFlag;
   logic [31:0] FetchCount;
   logic [31:0] PCResult2, IFID_Instruction2, IFID_PCPlus42;
   logic        IFID_Valid2, MisalignFlag2;
   logic [2:0]  FetchCount2;
   logic [31:0] PCAddResult2, Instruction2;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   always #5 Clk = ~Clk;

   // Hard-wired PC+4 adder and a PC-tagged instruction memory.
   assign PCAddResult  = PCResult + 32'd4;
   assign Instruction  = K ^ PCResult;
   assign PCAddResult2 = PCResult2 + 32'd4;
   assign Instruction2 = K ^ PCResult2;

   pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) u_dut (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget),
      .PCAddResult(PCAddResult), .Instruction(Instruction),
      .PCResult(PCResult), .IFID_Instruction(IFID_Instruction),
      .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
      .FetchCount(FetchCount), .MisalignFlag(MisalignFlag)
   );

   pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(3)) u_dut_w3 (
      .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget),
      .PCAddResult(PCAddResult2), .Instruction(Instruction2),
      .PCResult(PCResult2), .IFID_Instruction(IFID_Instruction2),
      .IFID_PCPlus4(IFID_PCPlus42), .IFID_Valid(IFID_Valid2),
      .FetchCount(FetchCount2), .MisalignFlag(MisalignFlag2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_pc"},   PCResult, 32'h0);
      check({tag, "_ins"},  IFID_Instruction, 32'h0);
      check({tag, "_pc4"},  IFID_PCPlus4, 32'h0);
      check({tag, "_vld"},  {31'h0, IFID_Valid}, 32'h0);
      check({tag, "_cnt"},  FetchCount, 32'h0);
      check({tag, "_mis"},  {31'h0, MisalignFlag}, 32'h0);
      check({tag, "_cnt3"}, {29'h0, FetchCount2}, 32'h0);
   endtask

   task automatic check_cap(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                            input logic [31:0] ins, input logic vld);
      check({tag, "_pc"},   PCResult, pc);
      check({tag, "_pc4"},  IFID_PCPlus4, pc4);
      check({tag, "_ins"},  IFID_Instruction, ins);
      check({tag, "_vld"},  {31'h0, IFID_Valid}, {31'h0, vld});
      check({tag, "_cnt"},  FetchCount, exp_cnt);
      check({tag, "_cnt3"}, {29'h0, FetchCount2}, {29'h0, exp_cnt[2:0]});
   endtask

   initial begin
      Rst = 1'b0; Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
      BranchTarget = 32'h0; JumpTarget = 32'h0;
      #12;
      check_reset("rst");
      Rst = 1'b1;

      // Free-run to PC=8
      edge_step(); exp_cnt = 1; check_cap("run1", 32'h4, 32'h4, K ^ 32'h0, 1'b1);
      edge_step(); exp_cnt = 2; check_cap("run2", 32'h8, 32'h8, K ^ 32'h4, 1'b1);

      // Two stall cycles at PC=8
      Stall = 1'b1;
      edge_step(); check_cap("stall1", 32'h8, 32'h8, K ^ 32'h4, 1'b1);
      edge_step(); check_cap("stall2", 32'h8, 32'h8, K ^ 32'h4, 1'b1);
      Stall = 1'b0;
      edge_step(); exp_cnt = 3; check_cap("run3", 32'hC,  32'hC,  K ^ 32'h8, 1'b1);
      edge_step(); exp_cnt = 4; check_cap("run4", 32'h10, 32'h10, K ^ 32'hC, 1'b1);

      // Flush alone: PC advances, IF/ID bubbles
      Flush = 1'b1;
      edge_step(); check_cap("flush", 32'h14, 32'h0, 32'h0, 1'b0);
      Flush = 1'b0;
      edge_step(); exp_cnt = 5; check_cap("postflush", 32'h18, 32'h18, K ^ 32'h14, 1'b1);

      // Branch overrides stall
      BranchTaken = 1'b1; BranchTarget = 32'h40; Stall = 1'b1;
      edge_step(); check_cap("br_stall", 32'h40, 32'h0, 32'h0, 1'b0);
      BranchTaken = 1'b0; Stall = 1'b0;
      edge_step(); exp_cnt = 6; check_cap("br_tgt", 32'h44, 32'h44, K ^ 32'h40, 1'b1);

      // Jump beats branch; misaligned unselected branch target is ignored
      Jump = 1'b1; JumpTarget = 32'h100; BranchTaken = 1'b1; BranchTarget = 32'h202;
      edge_step(); check_cap("jmp_br", 32'h100, 32'h0, 32'h0, 1'b0);
      check("jmp_br_mis", {31'h0, MisalignFlag}, 32'h0);
      BranchTaken = 1'b0; JumpTarget = 32'h103;
      edge_step(); check_cap("jmp_mis", 32'h100, 32'h0, 32'h0, 1'b0);
      check("jmp_mis_flag", {31'h0, MisalignFlag}, 32'h1);
      Jump = 1'b0;
      edge_step(); exp_cnt = 7; check_cap("post_jmp", 32'h104, 32'h104, K ^ 32'h100, 1'b1);
      check("mis_sticky", {31'h0, MisalignFlag}, 32'h1);

      // Captures across the 3-bit wrap point
      edge_step(); exp_cnt = 8; check_cap("wrap8", 32'h108, 32'h108, K ^ 32'h104, 1'b1);
      edge_step(); exp_cnt = 9; check_cap("wrap9", 32'h10C, 32'h10C, K ^ 32'h108, 1'b1);

      // Asynchronous reset mid-cycle during a stall
      Stall = 1'b1;
      edge_step(); check_cap("stall3", 32'h10C, 32'h10C, K ^ 32'h108, 1'b1);
      #2 Rst = 1'b0;
      #1 check_reset("arst");
      Stall = 1'b0;
      #1 Rst = 1'b1;
      edge_step(); exp_cnt = 1; check_cap("refetch", 32'h4, 32'h4, K ^ 32'h0, 1'b1);
      check("refetch_mis", {31'h0, MisalignFlag}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Owns the program counter and the IF/ID pipeline register for the MIPS datapath. Drives the current PC into the hard-wired PC+4 adder and takes the adder's result back as the sequential next PC. Selects among sequential, branch and jump next-PC sources, and honours hazard stalls and flushes. Captures the fetched instruction and its PC+4 into IF/ID for the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
CNT_W, 32, width of the fetch counter.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Rst  in  1  asynchronous, active-low reset.
Stall  in  1  load-use hazard hold from the hazard unit.
Flush  in  1  bubble IF/ID; does not affect the PC.
BranchTaken  in  1  resolved taken branch.
BranchTarget  in  32  branch destination address.
Jump  in  1  jump redirect.
JumpTarget  in  32  jump destination address.
PCAddResult  in  32  PC+4 returned from the adder.
Instruction  in  32  instruction memory read data for the current PC.
PCResult  out  32  current PC; feeds the adder and the instruction memory address.
IFID_Instruction  out  32  registered instruction.
IFID_PCPlus4  out  32  registered PC+4.
IFID_Valid  out  1  high when the IF/ID slot holds a real instruction.
FetchCount  out  CNT_W  number of instructions accepted into IF/ID.
MisalignFlag  out  1  sticky; set when a redirect target has bits [1:0] != 0.

Behaviour:
- Reset (Rst=0, asynchronous, regardless of clock): PCResult=RESET_PC; IFID_Instruction=0; IFID_PCPlus4=0; IFID_Valid=0; FetchCount=0; MisalignFlag=0.
- Reset mid-operation discards any in-flight redirect or stall. The first edge after Rst rises fetches RESET_PC.
- Next-PC priority at each edge:
  1. Jump=1: PC <= {JumpTarget[31:2],2'b00}.
  2. Else BranchTaken=1: PC <= {BranchTarget[31:2],2'b00}.
  3. Else Stall=1: PC holds.
  4. Else PC <= PCAddResult.
- A redirect overrides Stall. Jump overrides BranchTaken when both are asserted.
- Misaligned target: the low two bits are masked as above. MisalignFlag sets to 1 only when the selected target has [1:0] != 0, and stays set until reset.
- IF/ID update priority at each edge:
  1. Jump, BranchTaken or Flush asserted: bubble. IFID_Instruction=0 (NOP), IFID_PCPlus4=0, IFID_Valid=0.
  2. Else Stall=1: all IF/ID fields hold their values.
  3. Else capture: IFID_Instruction<=Instruction, IFID_PCPlus4<=PCAddResult, IFID_Valid<=1.
- FetchCount increments by 1 only on a capture edge. It wraps from all-ones to 0 with no flag.
- Latency: one cycle from PC to IF/ID. A redirect asserted in cycle N appears on PCResult after edge N, and its target instruction is in IF/ID after edge N+1.
- Arithmetic: no internal adder is used for PC+4. PCAddResult is trusted, and wrap from 32'hFFFF_FFFC to 0 follows from the adder.
- PCResult is the PC register output directly, with no combinational path from any input.

Test Plan:
- Reset then 4 free-running edges with Instruction=PC-derived pattern -> PCResult 0,4,8,C,10; IFID_PCPlus4 4,8,C,10; FetchCount=4; IFID_Valid=1 after edge 1.
- Stall=1 for 2 cycles at PC=8 -> PCResult stays 8, IF/ID holds the instruction from PC=4, FetchCount unchanged; resumes at C after release.
- BranchTaken=1 with BranchTarget=0x40 and Stall=1 in the same cycle -> PCResult=0x40, IFID_Valid=0, next edge IFID_PCPlus4=0x44.
- Jump=1 with JumpTarget=0x100 and BranchTaken=1 with BranchTarget=0x200 -> PCResult=0x100. Then JumpTarget=0x103 -> PCResult=0x100, MisalignFlag=1 and stays set.
- Flush=1 alone at PC=0x10 -> PC advances to 0x14, IFID_Valid=0 and IFID_Instruction=0, FetchCount unchanged.
- Rst pulled low asynchronously mid-cycle during a stall -> all outputs return to reset values immediately. Force FetchCount to all-ones, then one capture edge -> FetchCount=0.
